// File: rtl/spi_reg_peripheral.sv
// rtl/spi_reg_peripheral.sv - SPI mode-0 write target feeding the PWM control registers.
// Optional readback of registers on cipo when SPI_READBACK_EN is defined.
module spi_reg_peripheral #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       ncs,
    input  logic       copi,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_s, ncs_s, copi_s;
    logic [1:0]  state;
    logic [4:0]  bit_cnt;
    logic [15:0] shreg;
    logic        sclk_rise, sclk_fall, ncs_fall, ncs_rise, ncs_low, copi_bit;
    logic        commit_ok;

    // Sync chains reset low so a reset released mid-frame never fabricates an ncs falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s <= '0;
            ncs_s  <= '0;
            copi_s <= '0;
        end else begin
            sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
            ncs_s  <= {ncs_s[SYNC_STAGES-2:0], ncs};
            copi_s <= {copi_s[SYNC_STAGES-2:0], copi};
        end
    end

    assign sclk_rise = sclk_s[SYNC_STAGES-2] & ~sclk_s[SYNC_STAGES-1];
    assign sclk_fall = ~sclk_s[SYNC_STAGES-2] & sclk_s[SYNC_STAGES-1];
    assign ncs_fall  = ~ncs_s[SYNC_STAGES-2] & ncs_s[SYNC_STAGES-1];
    assign ncs_rise  = ncs_s[SYNC_STAGES-2] & ~ncs_s[SYNC_STAGES-1];
    assign ncs_low   = ~ncs_s[SYNC_STAGES-2];
    assign copi_bit  = copi_s[SYNC_STAGES-2];

    assign commit_ok = (bit_cnt == 5'd16) && shreg[15] && (shreg[14:8] <= MAX_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            shreg           <= '0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    shreg   <= '0;
                    if (ncs_fall) state <= SHIFT;
                end
                SHIFT: begin
                    if (ncs_rise) state <= COMMIT;
                    if (sclk_rise && ncs_low) begin
                        shreg <= {shreg[14:0], copi_bit};
                        // Saturating at 17 keeps over-long frames distinguishable from exact ones.
                        if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (commit_ok) begin
                        case (shreg[14:8])
                            7'h00:   en_reg_out_7_0  <= shreg[7:0];
                            7'h01:   en_reg_out_15_8 <= shreg[7:0];
                            7'h02:   en_reg_pwm_7_0  <= shreg[7:0];
                            7'h03:   en_reg_pwm_15_8 <= shreg[7:0];
                            7'h04:   pwm_duty_cycle  <= shreg[7:0];
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic [7:0] tx;
    logic       rd_active;
    logic [6:0] rb_addr;
    logic [7:0] rb_data;

    // Address is complete on the 8th rising edge: seven bits already shifted plus the current one.
    assign rb_addr = {shreg[5:0], copi_bit};

    always_comb begin
        rb_data = 8'h00;
        if (rb_addr <= MAX_ADDR) begin
            case (rb_addr)
                7'h00:   rb_data = en_reg_out_7_0;
                7'h01:   rb_data = en_reg_out_15_8;
                7'h02:   rb_data = en_reg_pwm_7_0;
                7'h03:   rb_data = en_reg_pwm_15_8;
                7'h04:   rb_data = pwm_duty_cycle;
                default: rb_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx        <= '0;
            rd_active <= 1'b0;
        end else if (state != SHIFT || !ncs_low) begin
            tx        <= '0;
            rd_active <= 1'b0;
        end else if (sclk_rise && bit_cnt == 5'd7) begin
            if (!shreg[6]) begin
                tx        <= rb_data;
                rd_active <= 1'b1;
            end
        end else if (sclk_fall && rd_active && bit_cnt >= 5'd9) begin
            tx <= {tx[6:0], 1'b0};
            if (bit_cnt >= 5'd16) rd_active <= 1'b0;
        end
    end

    assign cipo = rd_active & ncs_low & tx[7];
`else
    assign cipo = 1'b0;
`endif
endmodule

// File: tb/tb_spi_reg_peripheral.sv
// tb/tb_spi_reg_peripheral.sv - Table-driven and randomized bench for spi_reg_peripheral.
module tb_spi_reg_peripheral;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       ncs = 1'b1;
    logic       copi = 1'b0;
    logic       cipo;
    logic [7:0] r0, r1, r2, r3, r4;

    int checks = 0;
    int errors = 0;
    logic [7:0] mregs [5];
    logic cipo_high = 1'b0;

    spi_reg_peripheral dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ncs(ncs), .copi(copi), .cipo(cipo),
        .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
        .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cipo !== 1'b0) cipo_high = 1'b1;

    typedef struct {
        logic [16:0] data;
        int          nbits;
        logic [39:0] exp;
    } vec_t;

    function automatic logic [39:0] dut_regs();
        return {r4, r3, r2, r1, r0};
    endfunction

    function automatic logic [39:0] model_regs();
        return {mregs[4], mregs[3], mregs[2], mregs[1], mregs[0]};
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_frame(input logic [16:0] d, input int n);
        if (n == 16 && d[15] && d[14:8] <= 7'h04) mregs[d[10:8]] = d[7:0];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) mregs[i] = 8'h00;
    endtask

    // Sends n bits (d[n-1] first); cipo sampled just before each rising sclk edge.
    task automatic send(input logic [16:0] d, input int n, input int rst_after, output logic [15:0] rx);
        rx = '0;
        ncs = 1'b0;
        #80;
        for (int i = n - 1; i >= 0; i--) begin
            copi = d[i];
            #80;
            rx = {rx[14:0], cipo};
            sclk = 1'b1;
            #80;
            sclk = 1'b0;
            if (n - i == rst_after) begin
                rst_n = 1'b0;
                #30;
                check("reset_mid_frame_regs", dut_regs(), 40'h0);
                model_reset();
                rst_n = 1'b1;
                #20;
            end
        end
        #80;
        ncs = 1'b1;
        copi = 1'b0;
    endtask

    task automatic finish_frame(input string name);
        repeat (4) @(posedge clk);
        #1;
        check(name, dut_regs(), model_regs());
        #100;
    endtask

    vec_t vecs [8];
    logic [15:0] rx;
    logic [16:0] d;
    int n, r;

    initial begin
        vecs[0] = '{17'h080F0, 16, 40'h00_00_00_00_F0};
        vecs[1] = '{17'h08480, 16, 40'h80_00_00_00_F0};
        vecs[2] = '{17'h08555, 16, 40'h80_00_00_00_F0};
        vecs[3] = '{17'h04008, 15, 40'h80_00_00_00_F0};
        vecs[4] = '{17'h10045, 17, 40'h80_00_00_00_F0};
        vecs[5] = '{17'h00222, 16, 40'h80_00_00_00_F0};
        vecs[6] = '{17'h08233, 16, 40'h80_00_33_00_F0};
        vecs[7] = '{17'h080A5, 16, 40'h80_00_33_00_A5};

        model_reset();
        #23;
        check("reset_regs", dut_regs(), 40'h0);
        check("reset_cipo", {39'h0, cipo}, 40'h0);
        rst_n = 1'b1;
        #100;

        // Expected state is checked SYNC_STAGES+2 clk after ncs rises, covering commit latency.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].data, vecs[i].nbits, -1, rx);
            repeat (4) @(posedge clk);
            #1;
            check($sformatf("table_%0d", i), dut_regs(), vecs[i].exp);
            #100;
            model_frame(vecs[i].data, vecs[i].nbits);
        end

        send(17'h00400, 16, -1, rx);
`ifdef SPI_READBACK_EN
        check("readback_pwm", {32'h0, rx[7:0]}, {32'h0, mregs[4]});
`else
        check("readback_disabled", {24'h0, rx}, 40'h0);
`endif
        finish_frame("after_read");

        send(17'h081AA, 16, 10, rx);
        finish_frame("mid_reset_discard");
        send(17'h081AA, 16, -1, rx);
        model_frame(17'h081AA, 16);
        finish_frame("write_after_reset");
        check("write_after_reset_r1", {32'h0, r1}, {32'h0, 8'hAA});

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 4);
            n = (r == 0) ? 15 : (r == 4) ? 17 : 16;
            d = {$urandom} & 17'h1FFFF;
            if (n == 16) begin
                d[16] = 1'b0;
                d[15] = ($urandom_range(0, 3) != 0);
                d[14:8] = 7'($urandom_range(0, 6));
            end
            send(d, n, -1, rx);
            model_frame(d, n);
            finish_frame($sformatf("random_%0d", k));
        end

`ifndef SPI_READBACK_EN
        check("cipo_stayed_low", {39'h0, cipo_high}, 40'h0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
